pwm_compare_bank: RTL and testbench
===================================

Name: pwm_compare_bank

Overview:
- Multi-channel, parametrised successor to the single 4-bit compare-and-register cell in the fan/PWM datapath.
- One shared period counter drives CHANNELS independent duty comparators, each with a registered PWM output.
- Duty and period updates are double-buffered: written any time through a valid/ready port, applied only at a period boundary, so no runt or glitch pulses occur.
- Sits between the control logic (which produces duty values) and the output pins.

Parameters:
- WIDTH, 8, bit width of counter, period and duty values.
- CHANNELS, 4, number of PWM outputs.
- CH_W, $clog2(CHANNELS) (min 1), derived width of the channel index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  count enable; low freezes counter and outputs.
- period  in  WIDTH  requested period (terminal count); sampled at each boundary.
- wr_valid  in  1  duty write request.
- wr_ready  out  1  write port can accept.
- wr_ch  in  CH_W  target channel of the write.
- wr_duty  in  WIDTH  new duty value.
- pwm_out  out  CHANNELS  registered PWM outputs.
- cnt  out  WIDTH  current counter value.
- period_tick  out  1  one-cycle pulse: a new period has started.

Behaviour:
- Reset (async, rst=1) clears cnt, per_act, every duty_act, every pending value and pending flag, pwm_out, and period_tick to 0.
- Boundary condition: wrap = en && (cnt == per_act).
- Counter, with en=1: if wrap then cnt<=0, else cnt<=cnt+1. Period length is per_act+1 cycles.
- Boundary actions, all in the wrap cycle:
  - per_act<=period.
  - For each channel with its pending flag set, duty_act<=pending; the flag is then cleared.
- Compare, with en=1: pwm_out[i]<=(cnt < duty_act[i]) using the pre-edge cnt and duty_act. This is 1-cycle latency.
  - duty=0 gives constant low.
  - duty>per_act gives constant high.
- en=0: cnt, pwm_out, per_act and duty_act all hold; period_tick<=0. Writes are still accepted.
- period_tick<=wrap. It is high in the first cycle where cnt==0 and the new values are active.
- Handshake:
  - wr_ready = !wrap (combinational).
  - A write is accepted when wr_valid && wr_ready: pending[wr_ch]<=wr_duty and flag set.
  - Multiple writes to one channel within a period: last wins.
  - A write with wr_ch >= CHANNELS is accepted and discarded.
  - In the wrap cycle, wr_ready=0; the writer holds valid, and the write lands next cycle for the following period.
- Out of reset, per_act=0, so the first enabled cycle is a wrap that loads period and any pending duties.
- period=0: wrap every enabled cycle; pwm_out[i] = (duty_act[i] != 0).
- Reset mid-period: everything clears immediately and counting restarts from 0; pending writes are lost.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- Defined:
  - A direction register is added (reset = up).
  - The counter counts up 0..per_act, then down to 0; at per_act it turns around without repeating the value. Full period = 2*per_act cycles.
  - wrap = en && down && cnt==1, i.e. the next value is 0. Boundary actions and period_tick act on this wrap.
  - Compare rule is unchanged, giving symmetric pulses.
  - per_act=0: cnt stays 0 and wrap fires every enabled cycle.
- Undefined: edge-aligned up-counter as above, with no direction register.

Decomposition:
- Package pwm_pkg holds:
  - default WIDTH/CHANNELS constants;
  - a clog2-min-1 function for CH_W;
  - a typedef for a duty word.
- Sub-module pwm_channel, one instance per channel, contains:
  - pending register and flag;
  - duty_act;
  - the comparator and pwm_out flop.
- Its inputs are wr_hit, wr_duty, wrap, en, cnt.
- Counter, wrap, period shadow and handshake stay in the top.

Test Plan:
- Reset, then period=9, write ch0=3, ch1=0, ch2=10, en=1 → ch0 high 3 of every 10 cycles, ch1 always low, ch2 always high; period_tick every 10 cycles.
- Mid-period write ch0=7 at cnt=4 → waveform unchanged until the next period_tick, then 7-high/3-low.
- wr_valid held across the wrap cycle → wr_ready=0 exactly in the cycle cnt==per_act; write accepted next cycle; value applied one period later.
- Two writes to ch3 (2 then 5) within one period → ch3 uses 5; write with wr_ch=4 when CHANNELS=4 → no channel changes.
- en dropped at cnt=5 for 3 cycles → cnt and pwm_out frozen, period_tick low; resume continues from cnt=5. rst asserted mid-period → all outputs 0 asynchronously.
- PWM_CENTER_ALIGNED_EN with period=4, duty=2 → cnt 0,1,2,3,4,3,2,1,0…; pwm_out high while cnt<2; period_tick every 8 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults, channel-index width helper and duty word type for the PWM compare bank.
package pwm_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHANNELS = 4;
  typedef logic [DEF_WIDTH-1:0] duty_t;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: double-buffered duty register with registered compare output for one PWM channel.
module pwm_channel import pwm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);
  logic [WIDTH-1:0] pending, duty_act;
  logic             flag;
  // wr_hit never coincides with wrap because the write port is closed in the wrap cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      flag     <= 1'b0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr_hit) pending <= wr_duty;
      flag <= wr_hit ? 1'b1 : (wrap ? 1'b0 : flag);
      if (wrap && flag) duty_act <= pending;
      if (en) pwm <= cnt < duty_act;
    end
  end
endmodule

// File: rtl/pwm_compare_bank.sv
// pwm_compare_bank: shared period counter driving CHANNELS double-buffered PWM comparators.
// Define PWM_CENTER_ALIGNED_EN for an up/down (center-aligned) counter instead of the edge-aligned one.
module pwm_compare_bank import pwm_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CH_W     = clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [WIDTH-1:0]    period,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [WIDTH-1:0]    cnt,
  output logic                period_tick
);
  logic [WIDTH-1:0]    per_act;
  logic                wrap;
  logic [CHANNELS-1:0] wr_hit;
`ifdef PWM_CENTER_ALIGNED_EN
  logic down;
  // wrap whenever the next counter value is 0, including the short turnaround at per_act=1
  assign wrap = en && (per_act == '0 || (cnt == WIDTH'(1) && (down || per_act == WIDTH'(1))));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      down <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      down <= 1'b0;
    end else if (en) begin
      if (!down && cnt == per_act) down <= 1'b1;
      cnt <= (down || cnt == per_act) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
    end
  end
`else
  assign wrap = en && cnt == per_act;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + WIDTH'(1);
  end
`endif
  assign wr_ready = !wrap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_act     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (wrap) per_act <= period;
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign wr_hit[g] = wr_valid && wr_ready && wr_ch == CH_W'(g);
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .wrap    (wrap),
      .wr_hit  (wr_hit[g]),
      .wr_duty (wr_duty),
      .cnt     (cnt),
      .pwm     (pwm_out[g])
    );
  end
endmodule

// File: tb/tb_pwm_compare_bank.sv
// tb_pwm_compare_bank: directed and random stimulus checked against a phase-based reference model.
module tb_pwm_compare_bank;
  import pwm_pkg::*;
  localparam int W = 8;
  localparam int CH = 5;
  localparam int CW = clog2_min1(CH);
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, wr_valid = 1'b0;
  logic [W-1:0] period = '0, wr_duty = '0;
  logic [CW-1:0] wr_ch = '0;
  logic wr_ready, period_tick;
  logic [CH-1:0] pwm_out;
  logic [W-1:0] cnt;
  int n_cmp = 0, n_bad = 0;
  int m_per, m_phase;
  int m_duty[CH], m_pend[CH];
  bit m_flag[CH];
  logic [CH-1:0] m_pwm;
  bit m_tick;

  pwm_compare_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_duty(wr_duty), .pwm_out(pwm_out),
    .cnt(cnt), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one period is a sequence of phases; the counter value is a function of the phase
  function automatic int m_len();
`ifdef PWM_CENTER_ALIGNED_EN
    return (m_per == 0) ? 1 : 2 * m_per;
`else
    return m_per + 1;
`endif
  endfunction

  function automatic int m_cnt();
`ifdef PWM_CENTER_ALIGNED_EN
    return (m_phase <= m_per) ? m_phase : 2 * m_per - m_phase;
`else
    return m_phase;
`endif
  endfunction

  task automatic m_reset();
    m_per = 0; m_phase = 0; m_pwm = '0; m_tick = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0; m_pend[i] = 0; m_flag[i] = 0;
    end
  endtask

  task automatic step(input bit e, input bit v, input int ch, input int d, output bit acc);
    bit wrap;
    int c;
    en = e; wr_valid = v; wr_ch = CW'(ch); wr_duty = W'(d);
    #1;
    wrap = e && (m_phase == m_len() - 1);
    check("wr_ready", wr_ready, !wrap);
    @(posedge clk);
    c = m_cnt();
    if (e) for (int i = 0; i < CH; i++) m_pwm[i] = c < m_duty[i];
    if (wrap) begin
      m_per = period; m_phase = 0;
      for (int i = 0; i < CH; i++) if (m_flag[i]) begin
        m_duty[i] = m_pend[i]; m_flag[i] = 0;
      end
    end else if (e) m_phase++;
    acc = v && !wrap;
    if (acc && ch < CH) begin
      m_pend[ch] = d; m_flag[ch] = 1;
    end
    m_tick = wrap;
    #1;
    check("cnt", cnt, m_cnt());
    check("pwm_out", pwm_out, m_pwm);
    check("period_tick", period_tick, m_tick);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, acc);
  endtask

  task automatic wr_until(input int ch, input int d);
    bit acc = 0;
    for (int k = 0; k < 4 && !acc; k++) step(1, 1, ch, d, acc);
    check("write_accepted", acc, 1);
  endtask

  task automatic run_to_cnt(input int c);
    for (int k = 0; k < 64 && m_cnt() != c; k++) run(1);
    check("reached_cnt", m_cnt(), c);
  endtask

  initial begin
    bit acc;
    bit pv = 0;
    int pch = 0, pd = 0;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_cnt", cnt, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_tick", period_tick, 0);
    rst = 1'b0;
    period = 9;
    step(0, 1, 0, 3, acc);
    step(0, 1, 1, 0, acc);
    step(0, 1, 2, 10, acc);
    run(32);
    run_to_cnt(4);
    step(1, 1, 0, 7, acc);
    run(25);
    wr_until(3, 2);
    wr_until(3, 5);
    wr_until(5, 200);
    run(22);
    run_to_cnt(9);
    wr_until(4, 6);
    run(22);
    run_to_cnt(5);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, acc);
    run(14);
    run_to_cnt(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt", cnt, 0);
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_tick", period_tick, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    period = 4;
    wr_until(0, 2);
    run(20);
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 39) == 0) period = W'($urandom_range(0, 12));
      if (!pv && $urandom_range(0, 2) == 0) begin
        pv = 1; pch = $urandom_range(0, 7); pd = $urandom_range(0, 14);
      end
      step($urandom_range(0, 9) != 0, pv, pch, pd, acc);
      if (acc) pv = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
